// File: rtl/saxi_fifo_pkg.sv
// Shared definitions for the AXI-stream FIFO: depth helper and the per-cycle
// handshake classification used by the occupancy counter.
package saxi_fifo_pkg;

  typedef enum logic [1:0] {
    OpIdle = 2'b00,
    OpPush = 2'b01,
    OpPop  = 2'b10,
    OpBoth = 2'b11
  } fifo_op_e;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  function automatic fifo_op_e decode_op(input logic push, input logic pop);
    fifo_op_e op;
    unique case ({pop, push})
      2'b01:   op = OpPush;
      2'b10:   op = OpPop;
      2'b11:   op = OpBoth;
      default: op = OpIdle;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/saxi_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Kept separate so it can be swapped for a block-RAM macro later.
module saxi_fifo_ram
  import saxi_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/saxi_fifo.sv
// AXI-stream FIFO with first-word-fall-through output, registered input ready,
// fill level and almost-full flag.
module saxi_fifo
  import saxi_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_THRESH  = 12
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  output logic                  TREADY_IN,
  input  logic                  TVALID_IN,
  input  logic [DATA_WIDTH-1:0] TDATA_IN,
  input  logic                  TREADY_OUT,
  output logic                  TVALID_OUT,
  output logic [DATA_WIDTH-1:0] TDATA_OUT,
  output logic [ADDR_WIDTH:0]   LEVEL,
  output logic                  ALMOST_FULL
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   CntFull  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CntOne   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   AfThresh = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH-1:0] PtrOne   = (ADDR_WIDTH)'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  tready_q, tready_d;
  logic                  push, pop;
  fifo_op_e              op;

  assign push = TVALID_IN & tready_q;
  assign pop  = TVALID_OUT & TREADY_OUT;
  assign op   = decode_op(push, pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    unique case (op)
      OpPush:         count_d = count_q + CntOne;
      OpPop:          count_d = count_q - CntOne;
      OpIdle, OpBoth: count_d = count_q;
      default:        count_d = count_q;
    endcase
    // Ready looks at next occupancy only, so a pop while full re-opens the
    // input one cycle later without any combinational path from TREADY_OUT.
    tready_d = (count_d != CntFull);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tready_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tready_q <= tready_d;
    end
  end

  saxi_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk_i  (ACLK),
    .we_i   (push),
    .waddr_i(wr_ptr_q),
    .wdata_i(TDATA_IN),
    .raddr_i(rd_ptr_q),
    .rdata_o(TDATA_OUT)
  );

  assign TREADY_IN   = tready_q;
  assign TVALID_OUT  = (count_q != '0);
  assign LEVEL       = count_q;
  assign ALMOST_FULL = (count_q >= AfThresh);

endmodule

// File: tb/tb_saxi_fifo.sv
// Scoreboard bench for saxi_fifo: accepted words are queued as expected
// output, a monitor pops and compares on every output handshake.
module tb_saxi_fifo;

  logic        ACLK;
  logic        ARESETn;
  logic        TREADY_IN;
  logic        TVALID_IN;
  logic [31:0] TDATA_IN;
  logic        TREADY_OUT;
  logic        TVALID_OUT;
  logic [31:0] TDATA_OUT;
  logic [4:0]  LEVEL;
  logic        ALMOST_FULL;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] sb[$];

  saxi_fifo #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(4),
    .AF_THRESH (12)
  ) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .TREADY_IN  (TREADY_IN),
    .TVALID_IN  (TVALID_IN),
    .TDATA_IN   (TDATA_IN),
    .TREADY_OUT (TREADY_OUT),
    .TVALID_OUT (TVALID_OUT),
    .TDATA_OUT  (TDATA_OUT),
    .LEVEL      (LEVEL),
    .ALMOST_FULL(ALMOST_FULL)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Recorder and monitor share one process so queue order is deterministic.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [31:0] exp;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        prev_stall = 1'b0;
      end else begin
        if (TVALID_IN && TREADY_IN) sb.push_back(TDATA_IN);
        if (prev_stall) check("stall_stable", TDATA_OUT, prev_data);
        if (TVALID_OUT && TREADY_OUT) begin
          if (sb.size() == 0) begin
            check("unexpected_pop", {31'd0, TVALID_OUT}, 32'd0);
          end else begin
            exp = sb.pop_front();
            check("sb_data", TDATA_OUT, exp);
          end
        end
        prev_stall = TVALID_OUT && !TREADY_OUT;
        prev_data  = TDATA_OUT;
      end
    end
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    logic accepted;
    accepted = 1'b0;
    step();
    TVALID_IN = 1'b1;
    TDATA_IN  = d;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge ACLK);
      accepted = TREADY_IN;
      step();
    end
    TVALID_IN = 1'b0;
    check("push_accept", {31'd0, accepted}, 32'd1);
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge ACLK);
      if (!TVALID_OUT) break;
    end
    check("drain_done", {31'd0, TVALID_OUT}, 32'd0);
  endtask

  initial begin
    ARESETn    = 1'b0;
    TVALID_IN  = 1'b0;
    TDATA_IN   = '0;
    TREADY_OUT = 1'b0;

    // Reset and release
    repeat (3) step();
    check("rst_tready", {31'd0, TREADY_IN}, 32'd0);
    check("rst_tvalid", {31'd0, TVALID_OUT}, 32'd0);
    check("rst_level", {27'd0, LEVEL}, 32'd0);
    check("rst_af", {31'd0, ALMOST_FULL}, 32'd0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("tready_before_edge", {31'd0, TREADY_IN}, 32'd0);
    step();
    check("tready_after_edge", {31'd0, TREADY_IN}, 32'd1);

    // Fill to full with output stalled
    for (int k = 1; k <= 16; k++) begin
      push_word(32'(k));
      @(negedge ACLK);
      check("fill_level", {27'd0, LEVEL}, 32'(k));
      check("fill_af", {31'd0, ALMOST_FULL}, (k >= 12) ? 32'd1 : 32'd0);
    end
    check("full_tready", {31'd0, TREADY_IN}, 32'd0);
    step();
    TVALID_IN = 1'b1;
    TDATA_IN  = 32'h11;
    repeat (3) step();
    check("full_hold_level", {27'd0, LEVEL}, 32'd16);
    check("full_hold_tready", {31'd0, TREADY_IN}, 32'd0);
    TVALID_IN = 1'b0;

    // Drain one word per cycle
    TREADY_OUT = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge ACLK);
      check("drain_valid", {31'd0, TVALID_OUT}, 32'd1);
      check("drain_data", TDATA_OUT, 32'(i));
      if (i == 2) check("tready_reopen", {31'd0, TREADY_IN}, 32'd1);
    end
    @(negedge ACLK);
    check("drained_valid", {31'd0, TVALID_OUT}, 32'd0);
    check("drained_level", {27'd0, LEVEL}, 32'd0);
    step();
    TREADY_OUT = 1'b0;

    // Simultaneous push/pop at level 15 across pointer wrap
    for (int i = 0; i < 15; i++) push_word(32'h100 + 32'(i));
    @(negedge ACLK);
    check("wrap_prefill", {27'd0, LEVEL}, 32'd15);
    step();
    TREADY_OUT = 1'b1;
    TVALID_IN  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      TDATA_IN = 32'h200 + 32'(i);
      @(negedge ACLK);
      check("wrap_level", {27'd0, LEVEL}, 32'd15);
      check("wrap_tready", {31'd0, TREADY_IN}, 32'd1);
      step();
    end
    TVALID_IN = 1'b0;
    wait_empty(64);
    check("wrap_empty_level", {27'd0, LEVEL}, 32'd0);
    step();
    TREADY_OUT = 1'b0;

    // Bursty source, random sink
    for (int w = 0; w < 1000; w++) begin
      logic accepted;
      accepted   = 1'b0;
      TVALID_IN  = 1'b1;
      TDATA_IN   = 32'hA500_0000 + 32'(w);
      TREADY_OUT = 1'($urandom_range(0, 1));
      for (int t = 0; t < 100 && !accepted; t++) begin
        @(negedge ACLK);
        accepted = TREADY_IN;
        step();
        TREADY_OUT = 1'($urandom_range(0, 1));
      end
      TVALID_IN = 1'b0;
      if (!accepted) check("burst_accept", {31'd0, accepted}, 32'd1);
      repeat (5) begin
        step();
        TREADY_OUT = 1'($urandom_range(0, 1));
      end
    end
    TREADY_OUT = 1'b1;
    wait_empty(200);
    check("burst_sb_empty", 32'(sb.size()), 32'd0);
    step();
    TREADY_OUT = 1'b0;

    // Asynchronous reset with words in flight
    for (int i = 0; i < 7; i++) push_word(32'hC0 + 32'(i));
    @(negedge ACLK);
    check("pre_reset_level", {27'd0, LEVEL}, 32'd7);
    step();
    ARESETn = 1'b0;
    #1;
    check("async_tready", {31'd0, TREADY_IN}, 32'd0);
    check("async_tvalid", {31'd0, TVALID_OUT}, 32'd0);
    check("async_level", {27'd0, LEVEL}, 32'd0);
    check("async_af", {31'd0, ALMOST_FULL}, 32'd0);
    sb.delete();
    repeat (2) step();
    ARESETn = 1'b1;
    step();
    push_word(32'hBEEF_0001);
    push_word(32'hBEEF_0002);
    @(negedge ACLK);
    check("post_reset_valid", {31'd0, TVALID_OUT}, 32'd1);
    check("post_reset_first", TDATA_OUT, 32'hBEEF_0001);
    check("post_reset_level", {27'd0, LEVEL}, 32'd2);
    step();
    TREADY_OUT = 1'b1;
    wait_empty(20);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
